ps2_game_ctrl: RTL and testbench
================================

Name: ps2_game_ctrl

Overview:
Decodes PS/2 Set-2 scan-code bytes from the keyboard receiver into the level and pulse control signals consumed by vga_controller (move_left, move_right, fire, pause). Tracks the make, break and extended prefixes, holds per-key pressed state, and resolves left/right conflicts. It sits between the PS/2 byte receiver and the game/display logic, in the same clock domain as the display.

Parameters:
TIMEOUT_CYCLES, 2500000, cycles allowed between a prefix byte (E0/F0) and its follow-up byte before the parser aborts to IDLE (100 ms at 25 MHz).
TMR_W, 22, timer width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
iCLK  in  1  system/VGA clock; all logic on rising edge.
iRST  in  1  synchronous reset, active-high.
scan_code  in  8  received scan-code byte; valid only with scan_valid.
scan_valid  in  1  one-cycle strobe per received byte; back-to-back strobes legal.
move_left  out  1  level; left active per conflict rule.
move_right  out  1  level; right active per conflict rule.
fire  out  1  level; fire key held.
fire_pulse  out  1  one-cycle pulse on fire key press edge.
pause  out  1  toggled latch; 1 = game paused.

Behaviour:
- Clock and reset: one clock (iCLK). Reset iRST is synchronous and active-high.
- On reset: state=IDLE, timer=0, all held flags=0, last_dir=LEFT. move_left, move_right, fire, fire_pulse and pause all 0.
- Parser FSM (advances only on scan_valid):
  - IDLE: E0→EXT; F0→BRK; E1→IDLE, byte dropped; other→decode make (non-extended)→IDLE.
  - EXT: F0→EXT_BRK; E0→EXT; other→decode make (extended)→IDLE.
  - BRK: E0→EXT (protocol error, restart); F0→BRK; other→decode break (non-extended)→IDLE.
  - EXT_BRK: E0/F0→IDLE, no effect; other→decode break (extended)→IDLE.
- Pause/Break sequence (E1 14 77 E1 F0 14 F0 77): harmless. E1 is dropped; 14 and 77 are unmapped.
- Key map:
  - extended 6B = left arrow; extended 74 = right arrow.
  - non-extended 29 = space (fire); non-extended 4D = P (pause).
  - Any other code: no output change.
  - Extended and non-extended codes are distinct: non-extended 6B (keypad 4) is unmapped.
- 0xAA (BAT pass) received in IDLE: clears all held flags and pause, next cycle.
- Prefix timeout:
  - timer counts while state≠IDLE; it clears on every scan_valid and in IDLE.
  - When timer reaches TIMEOUT_CYCLES-1 with no scan_valid, state returns to IDLE next cycle.
  - scan_valid in the same cycle as the timeout wins: the byte is processed in the current state.
- Held flags: make sets the key's flag; break clears it. Repeated makes (typematic) are idempotent.
- Left/right conflict:
  - last_dir is updated only on a 0→1 transition of held_l or held_r.
  - move_left = held_l & (~held_r | last_dir==LEFT); move_right is symmetric.
  - Result: the newest press wins. When it is released, the other held key takes over the next cycle.
- fire = held_fire. fire_pulse = 1 for exactly one cycle when held_fire goes 0→1; typematic repeats produce no pulse.
- pause toggles on a P make only when held_p was 0; repeats are ignored. Break of P only clears held_p.
- Latency: all outputs are registered and change on the cycle after the scan_valid that carries the final byte.
- Mid-sequence reset: iRST has priority over everything; the FSM returns to IDLE and partial prefixes are discarded.

Optional Feature:
GAME_CTRL_WASD_EN:
- Defined: non-extended 1C (A) aliases left, 23 (D) aliases right, 1D (W) aliases fire.
  - Each alias has its own held flag. Effective held_l = arrow_l | key_a, and likewise for right and fire.
  - Releasing one source leaves the output asserted while the other source is held.
  - Conflict and pulse rules apply to the effective flags.
- Undefined: 1C, 23 and 1D are unmapped, and the extra flags are not synthesized.

Test Plan:
- Reset, then bytes E0 6B → move_left=1 one cycle after the 6B strobe; then E0 F0 6B → move_left=0; move_right stays 0 throughout.
- E0 6B, E0 74 → move_right=1, move_left=0; E0 F0 74 → move_left=1 on the next cycle; E0 F0 6B → both 0.
- 29, 29, 29 (typematic) → fire=1 and exactly one fire_pulse; then F0 29 → fire=0. Sequence 4D, 4D, F0 4D, 4D, F0 4D → pause goes 1, then 0.
- E0 followed by TIMEOUT_CYCLES idle cycles, then 6B → treated as non-extended and unmapped, so move_left=0. The same with 6B arriving at TIMEOUT_CYCLES-2 idle cycles → move_left=1.
- Hold left and fire with pause=1, then send AA → all outputs 0 next cycle. Assert iRST between E0 and F0, then send 6B → no output change (6B non-extended).
- With GAME_CTRL_WASD_EN: 1C, E0 6B, F0 1C → move_left stays 1; E0 F0 6B → move_left=0. Without the macro: 1C → no change.

Source files
------------

// File: rtl/ps2_game_ctrl.sv
// PS/2 Set-2 scan-code parser producing game controls (left/right/fire/pause).
// Optional macro GAME_CTRL_WASD_EN adds A/D/W aliases for left/right/fire.
module ps2_game_ctrl #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int TMR_W          = 22
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       fire_pulse,
  output logic       pause
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;
  localparam logic       DIR_LEFT  = 1'b0;
  localparam logic       DIR_RIGHT = 1'b1;

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             do_key, is_make, is_ext, bat;
  logic             arr_l_q, arr_l_d, arr_r_q, arr_r_d;
  logic             key_sp_q, key_sp_d, key_p_q, key_p_d;
  logic             pause_q, pause_d, last_dir_q, last_dir_d;
  logic             eff_l_q, eff_l_d, eff_r_q, eff_r_d, eff_f_q, eff_f_d;
  logic             move_left_q, move_right_q, fire_q, fire_pulse_q;
  logic             hit_l, hit_r, hit_sp, hit_p;

  // Parser: prefixes select make/break and extended/non-extended decode.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    do_key  = 1'b0;
    is_make = 1'b0;
    is_ext  = 1'b0;
    bat     = 1'b0;
    if (state_q != S_IDLE && !scan_valid) timer_d = timer_q + 1'b1;
    if (scan_valid) begin
      case (state_q)
        S_IDLE: begin
          if (scan_code == 8'hE0)      state_d = S_EXT;
          else if (scan_code == 8'hF0) state_d = S_BRK;
          else if (scan_code == 8'hAA) bat = 1'b1;
          else if (scan_code != 8'hE1) begin do_key = 1'b1; is_make = 1'b1; end
        end
        S_EXT: begin
          if (scan_code == 8'hF0) state_d = S_EXT_BRK;
          else if (scan_code != 8'hE0) begin
            do_key = 1'b1; is_make = 1'b1; is_ext = 1'b1; state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (scan_code == 8'hE0) state_d = S_EXT;
          else if (scan_code != 8'hF0) begin do_key = 1'b1; state_d = S_IDLE; end
        end
        default: begin
          state_d = S_IDLE;
          if (scan_code != 8'hE0 && scan_code != 8'hF0) begin do_key = 1'b1; is_ext = 1'b1; end
        end
      endcase
    end else if (state_q != S_IDLE && timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
    end
  end

  assign hit_l  = do_key &  is_ext & (scan_code == 8'h6B);
  assign hit_r  = do_key &  is_ext & (scan_code == 8'h74);
  assign hit_sp = do_key & ~is_ext & (scan_code == 8'h29);
  assign hit_p  = do_key & ~is_ext & (scan_code == 8'h4D);

  assign arr_l_d  = bat ? 1'b0 : (hit_l  ? is_make : arr_l_q);
  assign arr_r_d  = bat ? 1'b0 : (hit_r  ? is_make : arr_r_q);
  assign key_sp_d = bat ? 1'b0 : (hit_sp ? is_make : key_sp_q);
  assign key_p_d  = bat ? 1'b0 : (hit_p  ? is_make : key_p_q);
  // Only the first P make toggles; typematic repeats see key_p_q already set.
  assign pause_d  = bat ? 1'b0 : ((hit_p & is_make & ~key_p_q) ? ~pause_q : pause_q);

`ifdef GAME_CTRL_WASD_EN
  logic key_a_q, key_a_d, key_d_q, key_d_d, key_w_q, key_w_d;
  assign key_a_d = bat ? 1'b0 : ((do_key & ~is_ext & scan_code == 8'h1C) ? is_make : key_a_q);
  assign key_d_d = bat ? 1'b0 : ((do_key & ~is_ext & scan_code == 8'h23) ? is_make : key_d_q);
  assign key_w_d = bat ? 1'b0 : ((do_key & ~is_ext & scan_code == 8'h1D) ? is_make : key_w_q);
  assign eff_l_q = arr_l_q  | key_a_q;
  assign eff_r_q = arr_r_q  | key_d_q;
  assign eff_f_q = key_sp_q | key_w_q;
  assign eff_l_d = arr_l_d  | key_a_d;
  assign eff_r_d = arr_r_d  | key_d_d;
  assign eff_f_d = key_sp_d | key_w_d;
`else
  assign eff_l_q = arr_l_q;
  assign eff_r_q = arr_r_q;
  assign eff_f_q = key_sp_q;
  assign eff_l_d = arr_l_d;
  assign eff_r_d = arr_r_d;
  assign eff_f_d = key_sp_d;
`endif

  // Newest press wins: direction latches only on a rising effective flag.
  assign last_dir_d = (eff_l_d & ~eff_l_q) ? DIR_LEFT :
                      (eff_r_d & ~eff_r_q) ? DIR_RIGHT : last_dir_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      arr_l_q      <= 1'b0;
      arr_r_q      <= 1'b0;
      key_sp_q     <= 1'b0;
      key_p_q      <= 1'b0;
      pause_q      <= 1'b0;
      last_dir_q   <= DIR_LEFT;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      fire_q       <= 1'b0;
      fire_pulse_q <= 1'b0;
`ifdef GAME_CTRL_WASD_EN
      key_a_q      <= 1'b0;
      key_d_q      <= 1'b0;
      key_w_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      arr_l_q      <= arr_l_d;
      arr_r_q      <= arr_r_d;
      key_sp_q     <= key_sp_d;
      key_p_q      <= key_p_d;
      pause_q      <= pause_d;
      last_dir_q   <= last_dir_d;
      move_left_q  <= eff_l_d & (~eff_r_d | (last_dir_d == DIR_LEFT));
      move_right_q <= eff_r_d & (~eff_l_d | (last_dir_d == DIR_RIGHT));
      fire_q       <= eff_f_d;
      fire_pulse_q <= eff_f_d & ~eff_f_q;
`ifdef GAME_CTRL_WASD_EN
      key_a_q      <= key_a_d;
      key_d_q      <= key_d_d;
      key_w_q      <= key_w_d;
`endif
    end
  end

  assign move_left  = move_left_q;
  assign move_right = move_right_q;
  assign fire       = fire_q;
  assign fire_pulse = fire_pulse_q;
  assign pause      = pause_q;

endmodule

// File: tb/tb_ps2_game_ctrl.sv
// Bench for ps2_game_ctrl: directed scenarios plus random byte streams vs a key-set model.
module tb_ps2_game_ctrl;
  localparam int TO = 16;
  localparam int K_L = 0, K_R = 1, K_F = 2, K_P = 3, K_A = 4, K_D = 5, K_W = 6;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       move_left, move_right, fire, fire_pulse, pause;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending prefix flags, idle counter, held-key set, press-order queue.
  logic       m_ext, m_brk, m_pause, m_effl, m_effr, m_efff, m_fp;
  logic [6:0] m_held;
  int         m_cnt;
  int         dirq[$];

  ps2_game_ctrl #(.TIMEOUT_CYCLES(TO), .TMR_W(22)) dut (
    .iCLK(iCLK), .iRST(iRST), .scan_code(scan_code), .scan_valid(scan_valid),
    .move_left(move_left), .move_right(move_right), .fire(fire),
    .fire_pulse(fire_pulse), .pause(pause)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [4:0] dut_vec();
    return {move_left, move_right, fire, fire_pulse, pause};
  endfunction

  function automatic logic [4:0] exp_vec();
    logic ml, mr;
    ml = m_effl && (!m_effr || (dirq.size() > 0 && dirq[dirq.size()-1] == K_L));
    mr = m_effr && (!m_effl || (dirq.size() > 0 && dirq[dirq.size()-1] == K_R));
    return {ml, mr, m_efff, m_fp, m_pause};
  endfunction

  function automatic int key_of(input logic ext, input logic [7:0] c);
    if (ext && c == 8'h6B) return K_L;
    if (ext && c == 8'h74) return K_R;
    if (!ext && c == 8'h29) return K_F;
    if (!ext && c == 8'h4D) return K_P;
`ifdef GAME_CTRL_WASD_EN
    if (!ext && c == 8'h1C) return K_A;
    if (!ext && c == 8'h23) return K_D;
    if (!ext && c == 8'h1D) return K_W;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_pause = 0; m_effl = 0; m_effr = 0; m_efff = 0; m_fp = 0;
    m_held = '0; m_cnt = 0; dirq.delete();
  endtask

  task automatic model_key(input int k, input logic mk);
    if (k < 0) return;
    if (k == K_P && mk && !m_held[K_P]) m_pause = ~m_pause;
    m_held[k] = mk;
  endtask

  task automatic model_byte(input logic [7:0] c);
    if (!m_ext && !m_brk) begin
      if (c == 8'hE0) m_ext = 1;
      else if (c == 8'hF0) m_brk = 1;
      else if (c == 8'hAA) begin m_held = '0; m_pause = 0; end
      else if (c != 8'hE1) model_key(key_of(0, c), 1);
    end else if (m_ext && !m_brk) begin
      if (c == 8'hF0) m_brk = 1;
      else if (c != 8'hE0) begin model_key(key_of(1, c), 1); m_ext = 0; end
    end else if (!m_ext && m_brk) begin
      if (c == 8'hE0) begin m_ext = 1; m_brk = 0; end
      else if (c != 8'hF0) begin model_key(key_of(0, c), 0); m_brk = 0; end
    end else begin
      if (c != 8'hE0 && c != 8'hF0) model_key(key_of(1, c), 0);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic drop_dir(input int d);
    for (int i = 0; i < dirq.size(); i++)
      if (dirq[i] == d) begin dirq.delete(i); break; end
  endtask

  task automatic model_eff();
    logic nl, nr, nf;
    nl = m_held[K_L] | m_held[K_A];
    nr = m_held[K_R] | m_held[K_D];
    nf = m_held[K_F] | m_held[K_W];
    if (nl && !m_effl) dirq.push_back(K_L);
    if (!nl && m_effl) drop_dir(K_L);
    if (nr && !m_effr) dirq.push_back(K_R);
    if (!nr && m_effr) drop_dir(K_R);
    m_fp = nf && !m_efff;
    m_effl = nl; m_effr = nr; m_efff = nf;
  endtask

  // One clock: drive inputs, advance the model, leave the bench 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] c);
    @(negedge iCLK);
    scan_valid = v; scan_code = c;
    if (v) begin model_byte(c); m_cnt = 0; end
    else if (m_ext || m_brk) begin
      m_cnt++;
      if (m_cnt >= TO) begin m_ext = 0; m_brk = 0; end
    end
    model_eff();
    @(posedge iCLK); #1;
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST = 1'b1; scan_valid = 1'b0;
    model_reset();
    @(posedge iCLK); #1;
    iRST = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b1; scan_valid = 1'b0;
    repeat (2) @(posedge iCLK);
    #1; iRST = 1'b0; model_reset();
    n_cmp++; if (dut_vec() !== 5'b0) begin n_err++; $display("FAIL reset: got %b want %b", dut_vec(), 5'b0); end
  endtask

  task automatic test_arrows();
    do_reset();
    step(1, 8'hE0); step(1, 8'h6B);
    n_cmp++; if ({move_left, move_right} !== 2'b10) begin n_err++; $display("FAIL left_make: got %b want 10", {move_left, move_right}); end
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h6B);
    n_cmp++; if ({move_left, move_right} !== 2'b00) begin n_err++; $display("FAIL left_break: got %b want 00", {move_left, move_right}); end
  endtask

  task automatic test_conflict();
    do_reset();
    step(1, 8'hE0); step(1, 8'h6B); step(1, 8'hE0); step(1, 8'h74);
    n_cmp++; if ({move_left, move_right} !== 2'b01) begin n_err++; $display("FAIL newest_right: got %b want 01", {move_left, move_right}); end
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h74);
    n_cmp++; if ({move_left, move_right} !== 2'b10) begin n_err++; $display("FAIL left_takeover: got %b want 10", {move_left, move_right}); end
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h6B);
    n_cmp++; if ({move_left, move_right} !== 2'b00) begin n_err++; $display("FAIL both_released: got %b want 00", {move_left, move_right}); end
  endtask

  task automatic test_fire_pause();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin step(1, 8'h29); pulses += int'(fire_pulse); end
    step(0, 8'h00); pulses += int'(fire_pulse);
    n_cmp++; if (pulses !== 1 || fire !== 1'b1) begin n_err++; $display("FAIL fire_typematic: got pulses=%0d fire=%b want 1/1", pulses, fire); end
    step(1, 8'hF0); step(1, 8'h29);
    n_cmp++; if ({fire, fire_pulse} !== 2'b00) begin n_err++; $display("FAIL fire_release: got %b want 00", {fire, fire_pulse}); end
    step(1, 8'h4D);
    n_cmp++; if (pause !== 1'b1) begin n_err++; $display("FAIL pause_on: got %b want 1", pause); end
    step(1, 8'h4D); step(1, 8'hF0); step(1, 8'h4D);
    n_cmp++; if (pause !== 1'b1) begin n_err++; $display("FAIL pause_repeat: got %b want 1", pause); end
    step(1, 8'h4D); step(1, 8'hF0); step(1, 8'h4D);
    n_cmp++; if (pause !== 1'b0) begin n_err++; $display("FAIL pause_off: got %b want 0", pause); end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1, 8'hE0); idle(TO); step(1, 8'h6B);
    n_cmp++; if (move_left !== 1'b0) begin n_err++; $display("FAIL timeout_abort: got %b want 0", move_left); end
    step(1, 8'hE0); idle(TO - 2); step(1, 8'h6B);
    n_cmp++; if (move_left !== 1'b1) begin n_err++; $display("FAIL timeout_early: got %b want 1", move_left); end
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h6B);
    step(1, 8'hE0); idle(TO - 1); step(1, 8'h6B);
    n_cmp++; if (move_left !== 1'b1) begin n_err++; $display("FAIL timeout_edge_byte_wins: got %b want 1", move_left); end
  endtask

  task automatic test_bat_and_mid_reset();
    do_reset();
    step(1, 8'hE0); step(1, 8'h6B); step(1, 8'h29); step(1, 8'h4D);
    n_cmp++; if ({move_left, fire, pause} !== 3'b111) begin n_err++; $display("FAIL bat_setup: got %b want 111", {move_left, fire, pause}); end
    step(1, 8'hAA);
    n_cmp++; if (dut_vec() !== 5'b0) begin n_err++; $display("FAIL bat_clear: got %b want %b", dut_vec(), 5'b0); end
    step(1, 8'hE0); do_reset(); step(1, 8'h6B);
    n_cmp++; if (dut_vec() !== 5'b0) begin n_err++; $display("FAIL mid_reset_make: got %b want %b", dut_vec(), 5'b0); end
    step(1, 8'hE0); do_reset(); step(1, 8'hF0); step(1, 8'h6B);
    n_cmp++; if (dut_vec() !== 5'b0) begin n_err++; $display("FAIL mid_reset_break: got %b want %b", dut_vec(), 5'b0); end
  endtask

  task automatic test_wasd();
    do_reset();
`ifdef GAME_CTRL_WASD_EN
    step(1, 8'h1C); step(1, 8'hE0); step(1, 8'h6B); step(1, 8'hF0); step(1, 8'h1C);
    n_cmp++; if (move_left !== 1'b1) begin n_err++; $display("FAIL wasd_alias_hold: got %b want 1", move_left); end
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h6B);
    n_cmp++; if (move_left !== 1'b0) begin n_err++; $display("FAIL wasd_alias_release: got %b want 0", move_left); end
`else
    step(1, 8'h1C); step(1, 8'h23); step(1, 8'h1D);
    n_cmp++; if (dut_vec() !== 5'b0) begin n_err++; $display("FAIL wasd_unmapped: got %b want %b", dut_vec(), 5'b0); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] c;
    int r, gap;
    do_reset();
    for (int n = 0; n < 700; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15) c = 8'hE0;
      else if (r < 25) c = 8'hF0;
      else if (r < 27) c = 8'hE1;
      else if (r < 28) c = 8'hAA;
      else if (r < 40) c = 8'h6B;
      else if (r < 52) c = 8'h74;
      else if (r < 62) c = 8'h29;
      else if (r < 70) c = 8'h4D;
      else if (r < 78) c = 8'h1C;
      else if (r < 84) c = 8'h23;
      else if (r < 90) c = 8'h1D;
      else if (r < 95) c = (r[0]) ? 8'h14 : 8'h77;
      else c = 8'($urandom);
      step(1, c);
      n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL random_byte %0d code %h: got %b want %b", n, c, dut_vec(), exp_vec()); end
      r = $urandom_range(0, 99);
      gap = (r < 70) ? 0 : (r < 95) ? $urandom_range(1, 3) : $urandom_range(TO - 2, TO + 1);
      for (int g = 0; g < gap; g++) begin
        step(0, 8'h00);
        n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL random_idle %0d: got %b want %b", n, dut_vec(), exp_vec()); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arrows();
    test_conflict();
    test_fire_pause();
    test_timeout();
    test_bat_and_mid_reset();
    test_wasd();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
